// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands plus carry-in, then resolves
// one bit per cycle through a single full-adder slice, LSB first.
module serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_r;
    logic               cout_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               accept_s;
    logic               last_bit_s;
    logic               slice_sum_s;
    logic               slice_carry_s;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | ((x ^ y) & c);
    endfunction

    // Handshake flags; the low operand bits always hold the bit currently being added.
    always_comb begin
        accept_s      = in_valid && in_ready;
        last_bit_s    = (cnt_r == LAST_CNT);
        slice_sum_s   = fa_sum(a_r[0], b_r[0], carry_r);
        slice_carry_s = fa_carry(a_r[0], b_r[0], carry_r);
    end

    // Next-state logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, bit-serial datapath and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        cnt_r   <= '0;
                    end
                end
                RUN: begin
                    a_r     <= {1'b0, a_r[WIDTH-1:1]};
                    b_r     <= {1'b0, b_r[WIDTH-1:1]};
                    sum_r   <= {slice_sum_s, sum_r[WIDTH-1:1]};
                    carry_r <= slice_carry_s;
                    // Counter parks on the last index so it never wraps.
                    if (last_bit_s) begin
                        cout_r <= slice_carry_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE) && rst_n;
    assign out_valid = (state_r == DONE) && rst_n;
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=16): directed corner cases plus
// random operands compared against an arithmetic reference.
module tb_serial_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
    );

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation (caller guarantees IDLE), scrambles inputs while it runs,
    // and returns edges from handshake to out_valid (40 means timed out).
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         output int lat, output logic [W-1:0] s, output logic co);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        tick();
        lat = 0;
        while (!out_valid && lat < 40) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'($urandom);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        s = sum;
        co = cout;
    endtask

    task automatic test_reset();
        int lat; logic [W-1:0] s; logic co; logic [W:0] e;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        a = 16'h0001; b = 16'h0001; cin = 1'b0;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (sum !== 16'h0000 || cout !== 1'b0) begin errors++; $display("FAIL reset_result: got %h/%0b expected 0000/0", sum, cout); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %0b expected 1", in_ready); end
        do_op(16'h0001, 16'h0001, 1'b0, lat, s, co);
        e = ref_add(16'h0001, 16'h0001, 1'b0);
        checks++; if (lat !== 16) begin errors++; $display("FAIL first_latency: got %0d expected 16", lat); end
        checks++; if (s !== e[W-1:0] || co !== e[W]) begin errors++; $display("FAIL first_result: got %h/%0b expected %h/%0b", s, co, e[W-1:0], e[W]); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL first_release: got valid=%0b ready=%0b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [2] = '{16'hFFFF, 16'hFFFF};
        logic [W-1:0] tb [2] = '{16'h0001, 16'hFFFF};
        logic         tc [2] = '{1'b0, 1'b1};
        int lat; logic [W-1:0] s; logic co; logic [W:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            do_op(ta[i], tb[i], tc[i], lat, s, co);
            e = ref_add(ta[i], tb[i], tc[i]);
            checks++; if (lat !== 16) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected 16", i, lat); end
            checks++; if (s !== e[W-1:0] || co !== e[W]) begin errors++; $display("FAIL directed_result[%0d]: got %h/%0b expected %h/%0b", i, s, co, e[W-1:0], e[W]); end
            tick();
        end
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] s; logic co; logic [W:0] e; logic [W-1:0] x, y; logic c;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            x = W'($urandom); y = W'($urandom); c = 1'($urandom);
            do_op(x, y, c, lat, s, co);
            e = ref_add(x, y, c);
            checks++; if (lat !== 16) begin errors++; $display("FAIL random_latency[%0d]: got %0d expected 16", i, lat); end
            checks++; if (s !== e[W-1:0] || co !== e[W]) begin errors++; $display("FAIL random_result[%0d]: %h+%h+%0b got %h/%0b expected %h/%0b", i, x, y, c, s, co, e[W-1:0], e[W]); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [W-1:0] s; logic co; logic [W:0] e; logic [W-1:0] x, y;
        x = W'($urandom); y = W'($urandom);
        e = ref_add(x, y, 1'b1);
        out_ready = 1'b0;
        do_op(x, y, 1'b1, lat, s, co);
        checks++; if (s !== e[W-1:0] || co !== e[W]) begin errors++; $display("FAIL stall_result: got %h/%0b expected %h/%0b", s, co, e[W-1:0], e[W]); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            tick();
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_flags[%0d]: got valid=%0b ready=%0b expected 1/0", i, out_valid, in_ready); end
            checks++; if (sum !== e[W-1:0] || cout !== e[W]) begin errors++; $display("FAIL stall_hold[%0d]: got %h/%0b expected %h/%0b", i, sum, cout, e[W-1:0], e[W]); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got valid=%0b ready=%0b expected 0/1", out_valid, in_ready); end
        checks++; if (sum !== e[W-1:0] || cout !== e[W]) begin errors++; $display("FAIL idle_retain: got %h/%0b expected %h/%0b", sum, cout, e[W-1:0], e[W]); end
    endtask

    task automatic test_reset_abort();
        int lat; int pulses; logic [W-1:0] s; logic co; logic [W:0] e;
        out_ready = 1'b1;
        a = W'($urandom); b = W'($urandom); cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_during_reset: got ready=%0b valid=%0b expected 0/0", in_ready, out_valid); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin errors++; $display("FAIL abort_state: got valid=%0b %h/%0b expected 0 0000/0", out_valid, sum, cout); end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_result: got %0d pulses expected 0", pulses); end
        do_op(16'h1234, 16'h4321, 1'b0, lat, s, co);
        e = ref_add(16'h1234, 16'h4321, 1'b0);
        checks++; if (lat !== 16 || s !== e[W-1:0] || co !== e[W]) begin errors++; $display("FAIL abort_next_op: got lat=%0d %h/%0b expected 16 %h/%0b", lat, s, co, e[W-1:0], e[W]); end
        tick();
    endtask

    task automatic test_back_to_back();
        int hs[$]; int nres; int n; logic [W:0] e;
        nres = 0; n = 0;
        a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        e = ref_add(16'h8000, 16'h8000, 1'b0);
        while ((hs.size() < 3 || nres < 3) && n < 100) begin
            if (out_valid) begin
                nres++;
                checks++; if (sum !== e[W-1:0] || cout !== e[W]) begin errors++; $display("FAIL b2b_result[%0d]: got %h/%0b expected %h/%0b", nres, sum, cout, e[W-1:0], e[W]); end
            end
            if (in_valid && in_ready) hs.push_back(n + 1);
            tick();
            n++;
            if (hs.size() == 3) in_valid = 1'b0;
        end
        checks++; if (nres !== 3) begin errors++; $display("FAIL b2b_count: got %0d results expected 3", nres); end
        checks++;
        if (hs.size() !== 3) begin
            errors++; $display("FAIL b2b_handshakes: got %0d expected 3", hs.size());
        end else if (hs[1] - hs[0] !== 18 || hs[2] - hs[1] !== 18) begin
            errors++; $display("FAIL b2b_interval: got %0d,%0d expected 18,18", hs[1] - hs[0], hs[2] - hs[1]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; legal range 2..64.
REQ-002 Reset is synchronous and active-low, on a single clock.
REQ-003 Port clk: input, 1 bit. It is the single clock, and all state updates on its rising edge.
REQ-004 Port rst_n: input, 1 bit. It is the synchronous active-low reset.
REQ-005 Port in_valid: input, 1 bit. It means the operands are presented.
REQ-006 Port in_ready: output, 1 bit. It means the block can accept operands.
REQ-007 Port a: input, WIDTH bits. It is operand A.
REQ-008 Port b: input, WIDTH bits. It is operand B.
REQ-009 Port cin: input, 1 bit. It is the carry-in.
REQ-010 Port out_valid: output, 1 bit. It means sum and cout are valid.
REQ-011 Port out_ready: input, 1 bit. It means the consumer accepts the result.
REQ-012 Port sum: output, WIDTH bits. It is (a+b+cin) mod 2^WIDTH.
REQ-013 Port cout: output, 1 bit. It is bit WIDTH of a+b+cin.

Function
REQ-014 The state machine SHALL have three states: IDLE, RUN and DONE; the encoding is internal.
REQ-015 in_ready SHALL be 1 exactly when state==IDLE and rst_n==1; it is combinational from registered state.
REQ-016 out_valid SHALL be 1 exactly when state==DONE.
REQ-017 IDLE with in_valid&&in_ready: SHALL capture a, b and cin into internal registers, clear the bit counter, and go to RUN.
REQ-018 IDLE without a handshake: SHALL hold all state.
REQ-019 RUN: each cycle SHALL process one bit, LSB first, through one full-adder slice.
REQ-019a Slice sum bit: s = a_i ^ b_i ^ c.
REQ-019b Slice carry: c' = (a_i&b_i) | ((a_i^b_i)&c).
REQ-019c Per cycle: shift s into sum from the MSB side, register c', and increment the counter.
REQ-020 RUN, when the counter equals WIDTH-1: SHALL process the final bit, load cout with c', and go to DONE.
REQ-021 Latency: a handshake at edge k SHALL give out_valid=1 after edge k+WIDTH.
REQ-022 Minimum issue interval SHALL be WIDTH+2 cycles; a new operation is accepted only in IDLE.
REQ-023 DONE: sum and cout SHALL hold stable while out_ready==0, for any number of cycles.
REQ-024 DONE with out_ready==1: SHALL go to IDLE at that edge; out_valid drops the next cycle.
REQ-025 Changes on a, b, cin or in_valid outside IDLE SHALL NOT affect the result in progress.
REQ-026 sum and cout SHALL be registered outputs.
REQ-026a In IDLE they SHALL retain the last result.
REQ-026b During RUN, sum bits not yet written SHALL be don't-care, and DONE values SHALL be exact.
REQ-027 The counter SHALL be clog2(WIDTH) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-028 rst_n==0 at a rising edge SHALL force state=IDLE, sum=0, cout=0, carry register=0 and counter=0.
REQ-029 While rst_n==0, out_valid SHALL be 0 and in_ready SHALL be 0.
REQ-030 Reset asserted in RUN or DONE SHALL abort the operation, and no out_valid pulse SHALL follow.
REQ-031 The first edge with rst_n==1 and in_valid==1 SHALL be a valid handshake.

Verification (WIDTH=16)
REQ-032 Stimulus: a=0x0001, b=0x0001, cin=0, out_ready=1.
REQ-032a Required response: out_valid exactly 16 cycles after the handshake, with sum=0x0002 and cout=0.
REQ-033 Stimulus: a=0xFFFF, b=0x0001, cin=0.
REQ-033a Required response: sum=0x0000, cout=1; this exercises a full carry ripple.
REQ-034 Stimulus: a=0xFFFF, b=0xFFFF, cin=1.
REQ-034a Required response: sum=0xFFFF, cout=1.
REQ-035 Stimulus: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
REQ-035a Required response: sum and cout stay stable, in_ready=0, and the new operands are not accepted.
REQ-035b Then out_ready=1: the block goes to IDLE and in_ready=1 the next cycle.
REQ-036 Stimulus: rst_n=0 for one edge at RUN bit 7, then a=0x1234, b=0x4321, cin=0.
REQ-036a Required response after the reset edge: out_valid=0, sum=0 and cout=0, with no result for the aborted operation.
REQ-036b Required response for the new operation: sum=0x5555, cout=0.
REQ-037 Stimulus: in_valid and out_ready held at 1, with 3 back-to-back operands 0x8000+0x8000+0.
REQ-037a Required response: handshakes every 18 cycles, each result sum=0x0000 and cout=1.
